// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_evt_pkg;
  localparam int TS_W            = 16;
  localparam int CH_MAX_W        = 3;
  localparam int LOCKOUT_CYC_DEF = 50000;

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic [TS_W-1:0]     ts;
  } evt_t;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_edge_chan.sv
// One button channel: synchronizer, rising-edge detect, pending bit.
// Optional per-channel debounce lockout under BTN_EVT_LOCKOUT_EN.
module btn_edge_chan
  import btn_evt_pkg::*;
`ifdef BTN_EVT_LOCKOUT_EN
#(
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic grant,
  output logic pending,
  output logic drop
);

  // sync[1:0] is the two-flop synchronizer, sync[2] the previous synced level
  logic [2:0] sync;
  logic       rise;
  logic       accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[1:0], btn_in};
  end

  assign rise = sync[1] & ~sync[2];

`ifdef BTN_EVT_LOCKOUT_EN
  logic [15:0] lock_cnt;

  assign accept = rise && (lock_cnt == 16'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                lock_cnt <= '0;
    else if (accept)           lock_cnt <= 16'(LOCKOUT_CYC);
    else if (lock_cnt != 16'd0) lock_cnt <= lock_cnt - 16'd1;
  end
`else
  assign accept = rise;
`endif

  // A new edge landing in the grant cycle re-arms the bit instead of dropping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pending <= 1'b0;
    else if (accept) pending <= 1'b1;
    else if (grant)  pending <= 1'b0;
  end

  assign drop = accept & pending & ~grant;

endmodule

// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter, timestamp counter and FWFT event FIFO for button channels.
// BTN_EVT_LOCKOUT_EN enables the per-channel debounce lockout.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CH-1:0]               btn_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ch_w(N_CH)-1:0]         evt_ch,
  output logic [TS_W-1:0]               evt_ts,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW   = ch_w(N_CH);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  if (N_CH < 2 || N_CH > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LOCKOUT_CYC < 1 || LOCKOUT_CYC > 65535)
  begin : g_bad_cfg
    $error("btn_event_arbiter: parameter out of range");
  end

  logic [N_CH-1:0] pending, drop, grant;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    btn_edge_chan
`ifdef BTN_EVT_LOCKOUT_EN
      #(.LOCKOUT_CYC(LOCKOUT_CYC))
`endif
      u_chan (
        .clk     (clk),
        .reset   (reset),
        .btn_in  (btn_in[g]),
        .grant   (grant[g]),
        .pending (pending[g]),
        .drop    (drop[g])
      );
  end

  logic [TS_W-1:0] ts;
  logic [CW-1:0]   last, pick, idx;
  logic            found, push, pop, load;
  evt_t            push_evt, head;
  logic            head_vld;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] mem_cnt;
  evt_t            mem [FIFO_DEPTH];

  // Search starts one past the last winner; full gating uses the registered count
  always_comb begin
    grant = '0;
    found = 1'b0;
    pick  = last;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(last) + i) % N_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    push = found && (fifo_count < CNTW'(FIFO_DEPTH));
    if (push) grant[pick] = 1'b1;
  end

  assign push_evt = '{ch: CH_MAX_W'(pick), ts: ts};
  assign pop      = head_vld & evt_ready;
  // fifo_count includes the output register; mem_cnt is what sits behind it
  assign mem_cnt  = fifo_count - CNTW'(head_vld);
  assign load     = (!head_vld || pop) && (mem_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts         <= '0;
      last       <= CW'(N_CH - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      head_vld   <= 1'b0;
      head       <= '0;
      ovf        <= 1'b0;
    end else begin
      ts <= ts + 16'd1;
      if (push) begin
        last   <= pick;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        head     <= mem[rd_ptr];
        head_vld <= 1'b1;
        rd_ptr   <= rd_ptr + PW'(1);
      end else if (pop) begin
        head_vld <= 1'b0;
      end
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
      if (|drop)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign evt_valid = head_vld;
  assign evt_ch    = CW'(head.ch);
  assign evt_ts    = head.ts;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: vector table plus multi-cycle sequences.
module tb_btn_event_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_in = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_ch;
  logic [15:0] evt_ts;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [3:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int tpress;
  int got_ch[$];
  int got_ts[$];

  btn_event_arbiter #(.N_CH(4), .FIFO_DEPTH(8), .LOCKOUT_CYC(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_ts     (evt_ts),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // clk edges since reset release, i.e. the value the timestamp should hold
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] btn;
    logic       ready;
    logic       clr;
    logic       ev;
    int         ch;
    int         ts;
    int         cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    btn_in = m;
    tpress = cyc;
    repeat (3) @(negedge clk);
    btn_in = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input int ncyc);
    got_ch.delete();
    got_ts.delete();
    @(negedge clk);
    evt_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (evt_valid) begin
        got_ch.push_back(int'(evt_ch));
        got_ts.push_back(int'(evt_ts));
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(evt_valid), 0);
    chk({tag, "_count"}, int'(fifo_count), 0);
    chk({tag, "_ovf"},   int'(ovf), 0);
    chk({tag, "_ch"},    int'(evt_ch), 0);
    chk({tag, "_ts"},    int'(evt_ts), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    btn_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [16:0] pat;
    int          exp_ts[4];
    int          n_exp;

    //           btn    rdy   clr   ev    ch  ts  cnt ovf
    tbl[0]  = '{4'hF, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 1'b0, 1'b0, 0,  0,  1, 1'b0};
    tbl[4]  = '{4'hF, 1'b0, 1'b0, 1'b1, 0,  3,  2, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 1'b0, 1'b1, 0,  3,  3, 1'b0};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 1'b1, 1,  4,  3, 1'b0};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 1'b1, 2,  5,  2, 1'b0};
    tbl[8]  = '{4'hF, 1'b1, 1'b0, 1'b1, 3,  6,  1, 1'b0};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[10] = '{4'h0, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[11] = '{4'h4, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[12] = '{4'h4, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[13] = '{4'h4, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[14] = '{4'h4, 1'b0, 1'b0, 1'b0, 0,  0,  1, 1'b0};
    tbl[15] = '{4'h4, 1'b0, 1'b0, 1'b1, 2, 14,  1, 1'b0};
    tbl[16] = '{4'h4, 1'b1, 1'b0, 1'b0, 0,  0,  0, 1'b0};
    tbl[17] = '{4'h0, 1'b0, 1'b1, 1'b0, 0,  0,  0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Table: simultaneous press of all channels, then a single press on ch2
    reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      btn_in    = tbl[i].btn;
      evt_ready = tbl[i].ready;
      ovf_clr   = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
      chk($sformatf("v%0d_count", i), int'(fifo_count), tbl[i].cnt);
      chk($sformatf("v%0d_ovf", i),   int'(ovf), int'(tbl[i].ovf));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_ch", i), int'(evt_ch), tbl[i].ch);
        chk($sformatf("v%0d_ts", i), int'(evt_ts), tbl[i].ts);
      end
      @(negedge clk);
    end
    btn_in    = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Fill the FIFO, hold a pending event, then drop
    do_reset();
    press(4'hF);
    chk("fill4_count", int'(fifo_count), 4);
    press(4'hF);
    chk("fill8_count", int'(fifo_count), 8);
    press(4'h1);
    chk("full_count", int'(fifo_count), 8);
    chk("full_ovf", int'(ovf), 0);
    chk("full_valid", int'(evt_valid), 1);
    press(4'h1);
    chk("drop_ovf", int'(ovf), 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr_ovf", int'(ovf), 0);
    press(4'h1);
    chk("drop2_ovf", int'(ovf), 1);
    // One pop lets the held ch0 event in behind the remaining seven
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("refill_count", int'(fifo_count), 8);
    chk("refill_head_ch", int'(evt_ch), 1);

    // Reset mid-operation clears everything at once
    @(negedge clk);
    reset  = 1'b0;
    btn_in = '0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b1;
    press(4'h2);
    drain(8);
    chk("postrst_n", got_ch.size(), 1);
    if (got_ch.size() > 0) begin
      chk("postrst_ch", got_ch[0], 1);
      chk("postrst_ts", got_ts[0], tpress + 3);
    end
    chk("postrst_count", int'(fifo_count), 0);

    // Bounce on ch1 followed by a clean press 14 cycles after the first edge
    pat = 17'b11100000010110011;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      btn_in = {2'b00, pat[i], 1'b0};
    end
    @(negedge clk);
    btn_in = '0;
    repeat (6) @(negedge clk);
`ifdef BTN_EVT_LOCKOUT_EN
    n_exp = 2;
`else
    n_exp = 4;
`endif
    drain(10);
    chk("bounce_n", got_ch.size(), n_exp);
    foreach (got_ch[k]) chk($sformatf("bounce_ch%0d", k), got_ch[k], 1);
    chk("bounce_ovf", int'(ovf), 0);

    // Timestamp wrap across 0xFFFF
    do_reset();
    while (cyc < 65530) @(negedge clk);
    press(4'hF);
    exp_ts = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    drain(12);
    chk("wrap_n", got_ch.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_ch.size()) begin
        chk($sformatf("wrap_ch%0d", k), got_ch[k], k);
        chk($sformatf("wrap_ts%0d", k), got_ts[k], exp_ts[k]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects asynchronous, active-high push-button inputs from the watch front panel and turns each rising edge into a timestamped event. Pending events are arbitrated round-robin into a small event FIFO, which the HPS-facing register interface drains through a valid/ready handshake. The block sequences and shares one event path between all button channels, so no press is lost under contention and every drop is reported.

## Interface
- N_CH, 4, number of button channels (2..8)
- FIFO_DEPTH, 8, event FIFO entries (power of two, 2..16)
- LOCKOUT_CYC, 50000, debounce lockout length in clk cycles after an accepted edge (1..65535)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- btn_in  in  N_CH  raw asynchronous button levels, active-high
- evt_valid  out  1  head-of-FIFO event available
- evt_ready  in  1  consumer accepts the head event this cycle
- evt_ch  out  $clog2(N_CH)  channel index of the head event
- evt_ts  out  16  timestamp of the head event
- ovf  out  1  sticky: at least one edge was dropped
- ovf_clr  in  1  synchronous clear of ovf
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Per channel: two-flop synchronizer, then a rising-edge detector producing a one-cycle pulse (synchronized 0→1 transition only).
- An edge pulse sets the channel's pending bit. If the pending bit is already set, the edge is dropped and ovf is set.
- Arbiter: each cycle where any pending bit is set and fifo_count < FIFO_DEPTH, grant one channel, round-robin starting after the last granted channel (the pointer resets to channel N_CH-1, so channel 0 wins first). Push {channel, timestamp} and clear that pending bit.
- If the pending bit sets and clears in the same cycle, the set wins.
- When the FIFO is full, pending bits hold. Nothing is lost until a second edge arrives on an already-pending channel.
- Timestamp: free-running 16-bit clk counter, wraps 0xFFFF→0x0000 with no flag. The value is captured in the grant cycle.
- FIFO is first-word-fall-through: evt_ch and evt_ts are valid whenever evt_valid=1, and a pop occurs when evt_valid && evt_ready.
- Full gating: a push is gated on the start-of-cycle count, so no push happens while full even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
- ovf_clr and a same-cycle drop: the drop wins, and ovf stays 1.
- Reset values: all outputs 0; pending bits, pointers and counters 0; synchronizers 0. A reset mid-operation discards FIFO contents and pending events.

## Timing
- Latency from the first clk edge sampling btn_in high: evt_valid rises after 5 edges, provided the FIFO is empty, there is no contention and the channel is not locked out. Breakdown: sync 2, pending 1, push 1, output 1.
- Throughput is one push per cycle and one pop per cycle.
- Under all-channel contention, channel k is pushed in cycle order 0,1,…,N_CH-1.
- Outputs are registered, with no combinational path from evt_ready to evt_valid.

## Configuration
- BTN_EVT_LOCKOUT_EN defined:
  - After an accepted edge on a channel, further edges on that channel are ignored for LOCKOUT_CYC cycles.
  - Ignored edges do not count as drops and do not set ovf.
  - Each channel has its own 16-bit down-counter.
- BTN_EVT_LOCKOUT_EN undefined:
  - Lockout counters are not built and LOCKOUT_CYC is unused.
  - Every synchronized edge is accepted.

## Structure
- Shared package btn_evt_pkg holds:
  - TS_W = 16 and the event struct {ch, ts};
  - the channel-index width function;
  - the default LOCKOUT_CYC constant.
- Sub-module btn_edge_chan: one instance per channel. It contains the synchronizer, edge detector, optional lockout counter and pending bit, and exports pending/drop to the top.
- The top level contains the round-robin arbiter, timestamp counter, FIFO and ovf logic.

## Test plan
- **Single press:** btn_in[2] 0→1 held, FIFO empty, lockout off → evt_valid=1 five edges later with evt_ch=2 and evt_ts equal to the grant-cycle counter value; evt_ready=1 pops it → fifo_count=0.
- **Simultaneous press:** btn_in=4'b1111 in one cycle → four events in order ch 0,1,2,3, with evt_ts values consecutive (t, t+1, t+2, t+3).
- **Full then drop:**
  - With evt_ready=0 and FIFO_DEPTH=8, generate 9 edges on round-robin channels → fifo_count=8 and one pending bit held, ovf=0.
  - A second edge on that pending channel → ovf=1.
  - An ovf_clr pulse → ovf=0.
- **Lockout (macro defined, LOCKOUT_CYC=10):** a bounce of 3 pulses on ch1 within 8 cycles → exactly one event and ovf=0. A press 12 cycles after acceptance → a second event.
- **Timestamp wrap:** force the counter near 0xFFFE and press → evt_ts sequence crosses 0xFFFF→0x0000 correctly.
- **Reset mid-operation:** assert reset with 3 events queued and 2 pending → all outputs 0 immediately. After release, the first press yields an event on its own channel only.
